// File: rtl/img2col_stream.sv
// img2col_stream: buffers one IMG_SIZE x IMG_SIZE frame arriving in raster
// order, then streams every K x K stride-1 patch (flattened row-major) with
// its top-left coordinate, one patch per accepted output handshake.
module img2col_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_SIZE   = 28,
  parameter int K          = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_pixel,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [K*K*DATA_WIDTH-1:0]           out_patch,
  output logic [$clog2(IMG_SIZE-K+1)-1:0]     out_row,
  output logic [$clog2(IMG_SIZE-K+1)-1:0]     out_col,
  output logic                                out_last
);

  localparam int OUT_SIZE = IMG_SIZE - K + 1;
  localparam int POS_W    = $clog2(OUT_SIZE);
  localparam int NPIX     = IMG_SIZE * IMG_SIZE;
  localparam int ADDR_W   = $clog2(NPIX);
  localparam int PATCH_W  = K * K * DATA_WIDTH;

  localparam logic [POS_W-1:0]  POS_ZERO = {POS_W{1'b0}};
  localparam logic [POS_W-1:0]  POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] PIX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PIX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   pix_cnt_r;
  logic [POS_W-1:0]    row_r;
  logic [POS_W-1:0]    col_r;
  logic [POS_W-1:0]    row_next_s;
  logic [POS_W-1:0]    col_next_s;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic [PATCH_W-1:0]  patch_r;
  logic [PATCH_W-1:0]  patch_next_s;
  logic [ADDR_W-1:0]   tap_addr_s;
  logic [DATA_WIDTH-1:0] tap_pix_s;
  logic                in_fire_s;
  logic                out_fire_s;
  logic                load_done_s;

  logic [DATA_WIDTH-1:0] buf_r [NPIX];

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_patch = patch_r;
  assign out_row   = row_r;
  assign out_col   = col_r;
  assign out_last  = out_last_r;

  // Next FSM state and next patch coordinate (raster walk over patch origins).
  always_comb begin
    state_next_s = state_r;
    row_next_s   = row_r;
    col_next_s   = col_r;
    load_done_s  = 1'b0;
    case (state_r)
      ST_LOAD: begin
        if (in_fire_s && (pix_cnt_r == PIX_LAST)) begin
          load_done_s  = 1'b1;
          state_next_s = ST_EMIT;
          row_next_s   = POS_ZERO;
          col_next_s   = POS_ZERO;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_EMIT: begin
        if (out_fire_s) begin
          if (out_last_r) begin
            state_next_s = ST_LOAD;
            row_next_s   = POS_ZERO;
            col_next_s   = POS_ZERO;
          end else if (col_r < POS_LAST) begin
            col_next_s = col_r + POS_ONE;
          end else begin
            col_next_s = POS_ZERO;
            row_next_s = row_r + POS_ONE;
          end
        end else begin
          state_next_s = ST_EMIT;
        end
      end
      default: begin
        state_next_s = ST_LOAD;
        row_next_s   = POS_ZERO;
        col_next_s   = POS_ZERO;
      end
    endcase
  end

  // Gather the K x K window at the next coordinate; the pixel being written
  // on the final load handshake is forwarded since the buffer holds it only
  // after this edge.
  always_comb begin
    patch_next_s = {PATCH_W{1'b0}};
    tap_addr_s   = PIX_ZERO;
    tap_pix_s    = {DATA_WIDTH{1'b0}};
    for (int m = 0; m < K; m++) begin
      for (int n = 0; n < K; n++) begin
        tap_addr_s = ADDR_W'((int'(row_next_s) + m) * IMG_SIZE + int'(col_next_s) + n);
        if (load_done_s && (tap_addr_s == pix_cnt_r)) begin
          tap_pix_s = in_pixel;
        end else begin
          tap_pix_s = buf_r[tap_addr_s];
        end
        patch_next_s[(m*K+n)*DATA_WIDTH +: DATA_WIDTH] = tap_pix_s;
      end
    end
  end

  // FSM state, pixel counter and registered handshake/position outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_LOAD;
      pix_cnt_r   <= PIX_ZERO;
      row_r       <= POS_ZERO;
      col_r       <= POS_ZERO;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r <= state_next_s;
      row_r   <= row_next_s;
      col_r   <= col_next_s;
      if (load_done_s) begin
        pix_cnt_r <= PIX_ZERO;
      end else if (in_fire_s) begin
        pix_cnt_r <= pix_cnt_r + PIX_ONE;
      end else begin
        pix_cnt_r <= pix_cnt_r;
      end
      out_valid_r <= (state_next_s == ST_EMIT);
      in_ready_r  <= (state_next_s == ST_LOAD);
      out_last_r  <= (state_next_s == ST_EMIT) && (row_next_s == POS_LAST) &&
                     (col_next_s == POS_LAST);
    end
  end

  // Image buffer write port; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      buf_r[pix_cnt_r] <= in_pixel;
    end
  end

  // Registered patch; stable under backpressure because coordinate and
  // buffer are both frozen while emitting.
  always_ff @(posedge clk) begin
    patch_r <= patch_next_s;
  end

endmodule

// File: tb/tb_img2col_stream.sv
// Directed testbench for img2col_stream at default parameters.
module tb_img2col_stream;

  localparam int DW  = 8;
  localparam int IMG = 28;
  localparam int K   = 3;
  localparam int OUT = IMG - K + 1;
  localparam int NP  = OUT * OUT;
  localparam int PW  = K * K * DW;
  localparam int RW  = $clog2(OUT);
  localparam int FIRST_P [9] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
  localparam int LAST_P  [9] = '{213, 214, 215, 241, 242, 243, 13, 14, 15};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_patch;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_col;
  logic          out_last;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] img [IMG][IMG];

  always #5 clk = ~clk;

  img2col_stream #(.DATA_WIDTH(DW), .IMG_SIZE(IMG), .K(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_patch(out_patch),
    .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  function automatic logic [PW-1:0] exp_patch(input int r, input int c);
    logic [PW-1:0] v;
    for (int m = 0; m < K; m++)
      for (int n = 0; n < K; n++)
        v[(m*K+n)*DW +: DW] = img[r+m][c+n];
    return v;
  endfunction

  function automatic logic [PW-1:0] pack9(input int which);
    logic [PW-1:0] v;
    for (int e = 0; e < 9; e++)
      v[e*DW +: DW] = DW'((which == 0) ? FIRST_P[e] : LAST_P[e]);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind 0: ramp, 1: all 0xFF, 2: offset ramp. Returns 1 cycle after last handshake.
  task automatic load_frame(input int kind, input int gaps);
    int r, c;
    for (int p = 0; p < IMG*IMG; p++) begin
      r = p / IMG;
      c = p % IMG;
      if (kind == 0) img[r][c] = DW'((r*IMG + c) % 256);
      else if (kind == 1) img[r][c] = 8'hFF;
      else img[r][c] = DW'((r*IMG + c + 7) % 256);
      if (gaps != 0) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_pixel = DW'($urandom);
          step();
        end
      end
      in_valid = 1'b1;
      in_pixel = img[r][c];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_pixel = 8'h00;
    step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_row !== RW'(0) || out_col !== RW'(0)) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b v=%b l=%b r=%0d c=%0d expected rdy=1 v=0 l=0 r=0 c=0",
               in_ready, out_valid, out_last, out_row, out_col);
    end
  endtask

  task automatic test_frame();
    load_frame(0, 0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_row !== RW'(0) ||
        out_col !== RW'(0) || out_patch !== pack9(0)) begin
      errors++;
      $display("FAIL first_patch: got v=%b rdy=%b r=%0d c=%0d p=%h expected v=1 rdy=0 r=0 c=0 p=%h",
               out_valid, in_ready, out_row, out_col, out_patch, pack9(0));
    end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== RW'(i/OUT) || out_col !== RW'(i%OUT) ||
          out_last !== (i == NP-1) || out_patch !== exp_patch(i/OUT, i%OUT)) begin
        errors++;
        $display("FAIL frame_patch %0d: got v=%b r=%0d c=%0d l=%b p=%h expected v=1 r=%0d c=%0d l=%b p=%h",
                 i, out_valid, out_row, out_col, out_last, out_patch, i/OUT, i%OUT, i == NP-1,
                 exp_patch(i/OUT, i%OUT));
      end
      if (i == NP-1) begin
        checks++;
        if (out_patch !== pack9(1) || out_last !== 1'b1) begin
          errors++;
          $display("FAIL last_patch: got l=%b p=%h expected l=1 p=%h", out_last, out_patch, pack9(1));
        end
      end
      step();
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    load_frame(0, 0);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== RW'(i/OUT) || out_col !== RW'(i%OUT) ||
          out_last !== (i == NP-1) || out_patch !== exp_patch(i/OUT, i%OUT)) begin
        errors++;
        $display("FAIL bp_patch %0d: got v=%b r=%0d c=%0d l=%b p=%h expected v=1 r=%0d c=%0d l=%b p=%h",
                 i, out_valid, out_row, out_col, out_last, out_patch, i/OUT, i%OUT, i == NP-1,
                 exp_patch(i/OUT, i%OUT));
      end
      if (i == 3*OUT) begin
        checks++;
        if (out_row !== RW'(3) || out_col !== RW'(0)) begin
          errors++;
          $display("FAIL row_wrap: got r=%0d c=%0d expected r=3 c=0", out_row, out_col);
        end
      end
      if (i == 3*OUT + 7) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          checks++;
          if (out_valid !== 1'b1 || out_row !== RW'(3) || out_col !== RW'(7) ||
              out_last !== 1'b0 || out_patch !== exp_patch(3, 7)) begin
            errors++;
            $display("FAIL bp_hold %0d: got v=%b r=%0d c=%0d l=%b p=%h expected v=1 r=3 c=7 l=0 p=%h",
                     s, out_valid, out_row, out_col, out_last, out_patch, exp_patch(3, 7));
          end
        end
        out_ready = 1'b1;
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_input_stalls();
    load_frame(0, 1);
    in_valid = 1'b1;
    in_pixel = 8'hA5;
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_row !== RW'(i/OUT) ||
          out_col !== RW'(i%OUT) || out_patch !== exp_patch(i/OUT, i%OUT)) begin
        errors++;
        $display("FAIL stall_patch %0d: got v=%b rdy=%b r=%0d c=%0d p=%h expected v=1 rdy=0 r=%0d c=%0d p=%h",
                 i, out_valid, in_ready, out_row, out_col, out_patch, i/OUT, i%OUT,
                 exp_patch(i/OUT, i%OUT));
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    load_frame(0, 0);
    for (int i = 0; i < 10*OUT + 4; i++) step();
    checks++;
    if (out_row !== RW'(10) || out_col !== RW'(4) || out_patch !== exp_patch(10, 4)) begin
      errors++;
      $display("FAIL mid_pos: got r=%0d c=%0d p=%h expected r=10 c=4 p=%h",
               out_row, out_col, out_patch, exp_patch(10, 4));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_row !== RW'(0) || out_col !== RW'(0)) begin
      errors++;
      $display("FAIL mid_reset: got v=%b rdy=%b r=%0d c=%0d expected v=0 rdy=1 r=0 c=0",
               out_valid, in_ready, out_row, out_col);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_no_patch: got v=%b expected 0", out_valid);
    end
    load_frame(2, 0);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== RW'(i/OUT) || out_col !== RW'(i%OUT) ||
          out_last !== (i == NP-1) || out_patch !== exp_patch(i/OUT, i%OUT)) begin
        errors++;
        $display("FAIL fresh_patch %0d: got v=%b r=%0d c=%0d l=%b p=%h expected v=1 r=%0d c=%0d l=%b p=%h",
                 i, out_valid, out_row, out_col, out_last, out_patch, i/OUT, i%OUT, i == NP-1,
                 exp_patch(i/OUT, i%OUT));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] ones;
    ones = {PW{1'b1}};
    load_frame(1, 0);
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== RW'(i/OUT) || out_col !== RW'(i%OUT) ||
          out_last !== (i == NP-1) || out_patch !== ones) begin
        errors++;
        $display("FAIL b2b_patch %0d: got v=%b r=%0d c=%0d l=%b p=%h expected v=1 r=%0d c=%0d l=%b p=%h",
                 i, out_valid, out_row, out_col, out_last, out_patch, i/OUT, i%OUT, i == NP-1, ones);
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_input_stalls();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
